// File: rtl/jtframe_sync_filter_bit.sv
// One bit of the sync filter: accepts a new level only after DLY consecutive
// differing cen samples and emits registered one-clock rise/fall pulses.
module jtframe_sync_filter_bit #(
  parameter int   DLY   = 4,
  parameter logic INIT1 = 1'b0
) (
  input  logic rst,
  input  logic clk,
  input  logic cen,
  input  logic raw,
  output logic flt,
  output logic rise,
  output logic fall,
  output logic pulse_nxt
);

  localparam int CW = $clog2(DLY + 1);
  localparam logic [CW-1:0] LAST = CW'(DLY - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flt_q, flt_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Next-state: pulses default low so they clear on the next edge even without cen
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flt_d   = flt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE: begin
        if (cen && (raw != flt_q)) begin
          if (DLY == 1) begin
            flt_d  = raw;
            rise_d = raw;
            fall_d = ~raw;
          end else begin
            cnt_d   = CW'(1);
            state_d = PENDING;
          end
        end else begin
          state_d = STABLE;
        end
      end
      PENDING: begin
        if (!cen) begin
          state_d = PENDING;
        end else if (raw == flt_q) begin
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == LAST) begin
          flt_d   = raw;
          rise_d  = raw;
          fall_d  = ~raw;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      flt_q   <= INIT1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign flt       = flt_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign pulse_nxt = rise_d | fall_d;

endmodule

// File: rtl/jtframe_sync_filter.sv
// Multi-bit glitch filter and edge detector for already-synchronized inputs.
// chg is registered from the per-bit next-state pulses so it lines up with rise/fall.
module jtframe_sync_filter #(
  parameter int           W    = 1,
  parameter int           DLY  = 4,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         rst,
  input  logic         clk,
  input  logic         cen,
  input  logic [W-1:0] raw,
  output logic [W-1:0] flt,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall,
  output logic         chg
);

  if (DLY < 1 || DLY > 255) begin : g_bad_dly
    $error("jtframe_sync_filter: DLY=%0d outside 1..255", DLY);
  end

  logic [W-1:0] pulse_nxt;
  logic         chg_q, chg_d;

  for (genvar i = 0; i < W; i++) begin : g_bit
    jtframe_sync_filter_bit #(
      .DLY   (DLY),
      .INIT1 (INIT[i])
    ) u_bit (
      .rst       (rst),
      .clk       (clk),
      .cen       (cen),
      .raw       (raw[i]),
      .flt       (flt[i]),
      .rise      (rise[i]),
      .fall      (fall[i]),
      .pulse_nxt (pulse_nxt[i])
    );
  end

  // Combined change flag from the pulses about to be registered
  always_comb begin
    chg_d = |pulse_nxt;
  end

  // chg register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= 1'b0;
    end else begin
      chg_q <= chg_d;
    end
  end

  assign chg = chg_q;

endmodule

// File: tb/tb_jtframe_sync_filter.sv
// Directed bench: three filter instances (DLY=4, DLY=3 with INIT=F, DLY=1)
// exercised by one task per feature with hand-computed expectations.
module tb_jtframe_sync_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       cen_a = 1'b1;
  logic [3:0] raw_a = 4'h0;
  logic [3:0] flt_a, rise_a, fall_a;
  logic       chg_a;

  logic       cen_b = 1'b1;
  logic [3:0] raw_b = 4'hF;
  logic [3:0] flt_b, rise_b, fall_b;
  logic       chg_b;

  logic       cen_c = 1'b1;
  logic [0:0] raw_c = 1'b0;
  logic [0:0] flt_c, rise_c, fall_c;
  logic       chg_c;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  jtframe_sync_filter #(.W(4), .DLY(4), .INIT(4'h0)) dut_a (
    .rst(rst), .clk(clk), .cen(cen_a), .raw(raw_a),
    .flt(flt_a), .rise(rise_a), .fall(fall_a), .chg(chg_a)
  );

  jtframe_sync_filter #(.W(4), .DLY(3), .INIT(4'hF)) dut_b (
    .rst(rst), .clk(clk), .cen(cen_b), .raw(raw_b),
    .flt(flt_b), .rise(rise_b), .fall(fall_b), .chg(chg_b)
  );

  jtframe_sync_filter #(.W(1), .DLY(1), .INIT(1'b0)) dut_c (
    .rst(rst), .clk(clk), .cen(cen_c), .raw(raw_c),
    .flt(flt_c), .rise(rise_c), .fall(fall_c), .chg(chg_c)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (flt_a !== 4'h0 || rise_a !== 4'h0 || fall_a !== 4'h0 || chg_a !== 1'b0)
      $display("FAIL reset_a flt=%h rise=%h fall=%h chg=%b exp 0/0/0/0", flt_a, rise_a, fall_a, chg_a);
    else passes++;
    checks++; if (flt_c !== 1'b0 || chg_c !== 1'b0)
      $display("FAIL reset_c flt=%b chg=%b exp 0/0", flt_c, chg_c);
    else passes++;
    rst = 1'b0;
    tick(1);
    checks++; if (flt_b !== 4'hF) $display("FAIL reset_b_init flt=%h exp F", flt_b); else passes++;
    // Start a 1->0 step on bit 1 and reset it while pending
    raw_b = 4'hD;
    tick(2);
    checks++; if (flt_b !== 4'hF) $display("FAIL reset_pre flt=%h exp F", flt_b); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (flt_b !== 4'hF || rise_b !== 4'h0 || fall_b !== 4'h0 || chg_b !== 1'b0)
      $display("FAIL reset_mid flt=%h rise=%h fall=%h chg=%b exp F/0/0/0", flt_b, rise_b, fall_b, chg_b);
    else passes++;
    #2;
    rst = 1'b0;
    tick(2);
    checks++; if (flt_b !== 4'hF) $display("FAIL reset_lost flt=%h exp F", flt_b); else passes++;
    tick(1);
    checks++; if (flt_b !== 4'hD || fall_b !== 4'h2 || chg_b !== 1'b1)
      $display("FAIL reset_after flt=%h fall=%h chg=%b exp D/2/1", flt_b, fall_b, chg_b);
    else passes++;
    raw_b = 4'hF;
    tick(5);
  endtask

  task automatic test_clean_step;
    raw_a = 4'h1;
    tick(3);
    checks++; if (flt_a !== 4'h0 || rise_a !== 4'h0)
      $display("FAIL step_early flt=%h rise=%h exp 0/0", flt_a, rise_a);
    else passes++;
    tick(1);
    checks++; if (flt_a !== 4'h1 || rise_a !== 4'h1 || fall_a !== 4'h0 || chg_a !== 1'b1)
      $display("FAIL step_edge flt=%h rise=%h fall=%h chg=%b exp 1/1/0/1", flt_a, rise_a, fall_a, chg_a);
    else passes++;
    tick(1);
    checks++; if (flt_a !== 4'h1 || rise_a !== 4'h0 || chg_a !== 1'b0)
      $display("FAIL step_after flt=%h rise=%h chg=%b exp 1/0/0", flt_a, rise_a, chg_a);
    else passes++;
    raw_a = 4'h0;
    tick(6);
    checks++; if (flt_a !== 4'h0) $display("FAIL step_back flt=%h exp 0", flt_a); else passes++;
  endtask

  task automatic test_glitch;
    int pulses;
    pulses = 0;
    raw_a = 4'h1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      if (rise_a !== 4'h0 || chg_a !== 1'b0) pulses++;
    end
    raw_a = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (rise_a !== 4'h0 || fall_a !== 4'h0 || chg_a !== 1'b0) pulses++;
    end
    checks++; if (flt_a !== 4'h0) $display("FAIL glitch_flt flt=%h exp 0", flt_a); else passes++;
    checks++; if (pulses !== 0) $display("FAIL glitch_pulse count=%0d exp 0", pulses); else passes++;
    // Counter must have restarted: a fresh step needs the full 4 samples
    raw_a = 4'h1;
    tick(3);
    checks++; if (flt_a !== 4'h0) $display("FAIL glitch_restart flt=%h exp 0", flt_a); else passes++;
    tick(1);
    checks++; if (flt_a !== 4'h1) $display("FAIL glitch_refire flt=%h exp 1", flt_a); else passes++;
    raw_a = 4'h0;
    tick(6);
  endtask

  task automatic test_cen_gating;
    int first_low, fall_cnt, fall_at;
    first_low = 0; fall_cnt = 0; fall_at = 0;
    for (int i = 0; i < 10; i++) begin
      cen_b = (i % 3 == 0);
      raw_b = (i == 1) ? 4'hF : 4'hE;
      tick(1);
      if (flt_b[0] === 1'b0 && first_low == 0) first_low = i + 1;
      if (fall_b[0] === 1'b1) begin
        fall_cnt++;
        fall_at = i + 1;
      end
    end
    checks++; if (first_low !== 7) $display("FAIL cen_latency got=%0d exp 7", first_low); else passes++;
    checks++; if (fall_cnt !== 1 || fall_at !== 7)
      $display("FAIL cen_fall_width count=%0d at=%0d exp 1 at 7", fall_cnt, fall_at);
    else passes++;
    checks++; if (flt_b !== 4'hE || rise_b !== 4'h0)
      $display("FAIL cen_final flt=%h rise=%h exp E/0", flt_b, rise_b);
    else passes++;
    cen_b = 1'b1;
    raw_b = 4'hF;
    tick(5);
  endtask

  task automatic test_multi_bit;
    int chg_cnt;
    chg_cnt = 0;
    raw_a = 4'b0101;
    tick(3);
    if (chg_a === 1'b1) chg_cnt++;
    tick(1);
    checks++; if (rise_a !== 4'b0101 || flt_a !== 4'b0101 || chg_a !== 1'b1)
      $display("FAIL multi_rise rise=%b flt=%b chg=%b exp 0101/0101/1", rise_a, flt_a, chg_a);
    else passes++;
    if (chg_a === 1'b1) chg_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      if (chg_a === 1'b1) chg_cnt++;
    end
    checks++; if (chg_cnt !== 1) $display("FAIL multi_chg count=%0d exp 1", chg_cnt); else passes++;
  endtask

  task automatic test_dly1;
    logic exp_v;
    int   bad;
    bad = 0;
    exp_v = 1'b0;
    for (int i = 0; i < 6; i++) begin
      exp_v = ~exp_v;
      raw_c = exp_v;
      tick(1);
      if (flt_c !== exp_v || rise_c !== exp_v || fall_c !== ~exp_v || chg_c !== 1'b1) begin
        bad++;
        $display("FAIL dly1_step%0d flt=%b rise=%b fall=%b chg=%b exp %b/%b/%b/1",
                 i, flt_c, rise_c, fall_c, chg_c, exp_v, exp_v, ~exp_v);
      end
    end
    checks++; if (bad == 0) passes++;
    cen_c = 1'b0;
    raw_c = 1'b1;
    tick(1);
    checks++; if (flt_c !== 1'b0 || rise_c !== 1'b0 || fall_c !== 1'b0 || chg_c !== 1'b0)
      $display("FAIL dly1_nocen flt=%b rise=%b fall=%b chg=%b exp 0/0/0/0", flt_c, rise_c, fall_c, chg_c);
    else passes++;
    cen_c = 1'b1;
    tick(1);
    checks++; if (flt_c !== 1'b1 || rise_c !== 1'b1)
      $display("FAIL dly1_cen flt=%b rise=%b exp 1/1", flt_c, rise_c);
    else passes++;
  endtask

  initial begin
    test_reset;
    test_clean_step;
    test_glitch;
    test_cen_gating;
    test_multi_bit;
    test_dly1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
